branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
Programmable instruction-address sequencer for the lab processor datapath. It generates InstrAddr for the instruction ROM, and branches come from a small runtime-loaded table keyed on address plus an ALUFlags condition, rather than hard-coded compare constants. Each table entry is written by the host/testbench configuration port. The block also provides start/stall/halt control, so one ROM program can run, pause and restart without resynthesis.

Parameters:
ADDR_W, 8, width of InstrAddr; all address arithmetic is modulo 2**ADDR_W.
NUM_ENTRIES, 8, number of branch-table entries (power of two, 2..16).
HALT_ADDR, 31, address at which the sequencer parks and asserts halted.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (reset==0 resets immediately; released synchronously by the user).
start  input  1  level; begins or restarts execution (see Behaviour).
stall  input  1  holds InstrAddr while high in RUN.
ALUFlags  input  4  flags of the instruction at the current InstrAddr: [0]=Z, [1]=C, [2]=V, [3]=N.
cfg_we  input  1  table write strobe.
cfg_idx  input  log2(NUM_ENTRIES)  entry index for the write.
cfg_data  input  2*ADDR_W+3  {match_addr[ADDR_W-1:0], cond[2:0], target[ADDR_W-1:0]}, MSB first.
InstrAddr  output  ADDR_W  current instruction address (registered).
running  output  1  high in RUN state.
halted  output  1  high in HALT state.
branch_taken  output  1  registered one-cycle pulse; the last update was a taken branch.

Behaviour:
- Reset (reset==0): InstrAddr=0, state=IDLE, running=0, halted=0, branch_taken=0. All table entries cleared to match_addr=0, cond=0, target=0.
- Table writes: when cfg_we=1, entry cfg_idx loads cfg_data at the clock edge. Writes are legal in any state. A write and a lookup of the same entry in the same cycle use the old contents.
- Condition codes:
  - 0 never
  - 1 Z=1
  - 2 Z=0
  - 3 C=1
  - 4 C=0
  - 5 N=1
  - 6 N=0
  - 7 always
- Entry hit: match_addr==InstrAddr and cond true for the current ALUFlags. With multiple hits, the lowest index wins.
- States:
  - IDLE: InstrAddr held at 0. start=1 -> RUN; InstrAddr stays 0 on that edge, and the first instruction is 0.
  - RUN, stall=1: InstrAddr holds, branch_taken=0, no table evaluation.
  - RUN, InstrAddr==HALT_ADDR: -> HALT, InstrAddr holds. HALT_ADDR takes priority over any table hit at that address.
  - RUN, table hit: InstrAddr<=target, branch_taken<=1. A target equal to InstrAddr is a legal self-loop.
  - RUN, otherwise: InstrAddr<=InstrAddr+1, wrapping at 2**ADDR_W-1 -> 0; branch_taken<=0.
  - HALT: InstrAddr held at HALT_ADDR, halted=1. start=1 -> InstrAddr<=0 and state=RUN on the same edge.
  - start is ignored while in RUN.
- Latency: one clock from flags/condition to the new InstrAddr. No pipelining; ALUFlags must be valid combinationally for the current InstrAddr.
- Reset asserted mid-operation returns the block to IDLE at once. Table contents are lost.

Optional Feature:
Macro BRANCH_SEQ_TAKEN_CNT_EN.
- Defined:
  - Extra output taken_count[15:0], cleared by reset and by each IDLE->RUN or HALT->RUN transition.
  - Increments on every taken branch and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start=1 with an empty table -> InstrAddr counts 0,1,2,...,31, then halted=1 with InstrAddr stuck at 31 for 10 further cycles.
- Entry 0 = {match 4, cond 1 (Z=1), target 1}; drive Z=1 at addr 4 for two visits, then Z=0 -> sequence 0,1,2,3,4,1,2,3,4,1,2,3,4,5. branch_taken pulses exactly twice.
- Entry 2 = {8, cond 2, 8} and entry 1 = {8, cond 7, 20}; Z=0 at addr 8 -> entry 1 wins, InstrAddr 8->20.
- Assert stall for 3 cycles at InstrAddr=6 -> InstrAddr reads 6,6,6,6 then 7; no branch_taken.
- Drop reset at InstrAddr=12 mid-run -> InstrAddr=0, running=0 immediately; the cond-7 entry is cleared, and a restart passes address 8 without branching.
- With BRANCH_SEQ_TAKEN_CNT_EN defined, run the loop scenario -> taken_count=2 at HALT; start from HALT -> taken_count returns to 0 and InstrAddr to 0.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: instruction-address sequencer with a runtime-loaded branch table.
// Latency: one clock from ALUFlags / table hit to the new InstrAddr; nothing is pipelined.
// Backpressure: stall=1 in RUN freezes InstrAddr and suppresses table evaluation.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   start        level; IDLE->RUN, or HALT->RUN restarting from address 0; ignored in RUN
//   stall        hold InstrAddr while in RUN
//   ALUFlags     {N,V,C,Z} for the instruction at the current InstrAddr
//   cfg_we/cfg_idx/cfg_data   table write port, cfg_data = {match_addr, cond, target}
//   InstrAddr    registered instruction address
//   running, halted           state indications
//   branch_taken registered pulse: the last address update was a taken branch
//   taken_count  (only with BRANCH_SEQ_TAKEN_CNT_EN) saturating count of taken branches
//
// Optional feature macro: BRANCH_SEQ_TAKEN_CNT_EN adds the taken_count[15:0] output.
module branch_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int NUM_ENTRIES = 8,
    parameter int HALT_ADDR   = 31,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CFG_W      = 2 * ADDR_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic [3:0]        ALUFlags,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CFG_W-1:0]  cfg_data,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              running,
    output logic              halted,
    output logic              branch_taken
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
    ,
    output logic [15:0]       taken_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              taken_d;

    // ------------------------------------------------------------------
    // Branch table
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] tab_match  [NUM_ENTRIES];
    logic [2:0]        tab_cond   [NUM_ENTRIES];
    logic [ADDR_W-1:0] tab_target [NUM_ENTRIES];

    logic [ADDR_W-1:0] cfg_match;
    logic [2:0]        cfg_cond;
    logic [ADDR_W-1:0] cfg_target;

    assign cfg_match  = cfg_data[CFG_W-1 -: ADDR_W];
    assign cfg_cond   = cfg_data[ADDR_W +: 3];
    assign cfg_target = cfg_data[ADDR_W-1:0];

    // A write lands at the edge, so a lookup of the same entry in that
    // cycle naturally sees the old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tab_match[i]  <= '0;
                tab_cond[i]   <= '0;
                tab_target[i] <= '0;
            end
        end else if (cfg_we) begin
            tab_match[cfg_idx]  <= cfg_match;
            tab_cond[cfg_idx]   <= cfg_cond;
            tab_target[cfg_idx] <= cfg_target;
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation and hit selection
    // ------------------------------------------------------------------
    logic flag_z;
    logic flag_c;
    logic flag_n;
    logic flag_v_unused;    // no condition code looks at overflow

    assign flag_z        = ALUFlags[0];
    assign flag_c        = ALUFlags[1];
    assign flag_v_unused = ALUFlags[2];
    assign flag_n        = ALUFlags[3];

    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic z, input logic c, input logic n);
        logic r;
        case (cond)
            3'd0:    r = 1'b0;
            3'd1:    r = z;
            3'd2:    r = ~z;
            3'd3:    r = c;
            3'd4:    r = ~c;
            3'd5:    r = n;
            3'd6:    r = ~n;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [NUM_ENTRIES-1:0] hit;
    logic                   hit_any;
    logic [ADDR_W-1:0]      hit_target;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit[i] = (tab_match[i] == InstrAddr) &&
                     cond_true(tab_cond[i], flag_z, flag_c, flag_n);
        end
    end

    // Scanning from the top down lets the lowest-index hit overwrite the rest.
    always_comb begin
        hit_any    = |hit;
        hit_target = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_target = tab_target[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            InstrAddr    <= '0;
            branch_taken <= 1'b0;
        end else begin
            state_q      <= state_d;
            InstrAddr    <= addr_d;
            branch_taken <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = InstrAddr;
        taken_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Address 0 is the first instruction after the start edge.
                addr_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    // The park address wins over any table entry matching it.
                    if (InstrAddr == HALT_A) begin
                        state_d = S_HALT;
                    end else if (hit_any) begin
                        addr_d  = hit_target;
                        taken_d = 1'b1;
                    end else begin
                        addr_d = InstrAddr + 1'b1;
                    end
                end
            end
            S_HALT: begin
                addr_d = HALT_A;
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign running = (state_q == S_RUN);
    assign halted  = (state_q == S_HALT);

`ifdef BRANCH_SEQ_TAKEN_CNT_EN
    // ------------------------------------------------------------------
    // Taken-branch counter, cleared whenever a program (re)starts
    // ------------------------------------------------------------------
    logic        restart;
    logic [15:0] cnt_q;

    assign restart = (state_q != S_RUN) && (state_d == S_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (taken_d && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign taken_count = cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed scenarios plus a randomized run of branch_sequencer,
// each cycle compared against a behavioural model of the sequencer rules.
module tb_branch_sequencer;

    localparam int NE   = 8;
    localparam int HALT = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [3:0]  ALUFlags;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [18:0] cfg_data;
    logic [7:0]  InstrAddr;
    logic        running;
    logic        halted;
    logic        branch_taken;
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
    logic [15:0] taken_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_sequencer #(.ADDR_W(8), .NUM_ENTRIES(NE), .HALT_ADDR(HALT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .ALUFlags     (ALUFlags),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_data     (cfg_data),
        .InstrAddr    (InstrAddr),
        .running      (running),
        .halted       (halted),
        .branch_taken (branch_taken)
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        ,
        .taken_count  (taken_count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_RUN, M_HALT} mmode_t;

    mmode_t m_mode;
    int     m_addr;
    bit     m_taken;
    int     m_cnt;
    int     m_match [NE];
    int     m_cond  [NE];
    int     m_tgt   [NE];

    // Codes 1..6 come in pairs per flag (Z, C, N); odd code = flag set.
    function automatic bit cond_holds(int c, logic [3:0] f);
        int fb;
        if (c == 0) return 1'b0;
        if (c == 7) return 1'b1;
        fb = (c <= 2) ? 0 : (c <= 4) ? 1 : 3;
        return f[fb] == ((c % 2) == 1);
    endfunction

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_addr  = 0;
        m_taken = 1'b0;
        m_cnt   = 0;
        for (int i = 0; i < NE; i++) begin
            m_match[i] = 0;
            m_cond[i]  = 0;
            m_tgt[i]   = 0;
        end
    endfunction

    function automatic void model_edge(bit st, bit sl, logic [3:0] f, bit we, int idx,
                                       logic [18:0] d);
        int first = -1;
        m_taken = 1'b0;
        if (m_mode == M_IDLE) begin
            if (st) begin
                m_mode = M_RUN;
                m_cnt  = 0;
            end
        end else if (m_mode == M_HALT) begin
            if (st) begin
                m_mode = M_RUN;
                m_addr = 0;
                m_cnt  = 0;
            end
        end else if (!sl) begin
            if (m_addr == HALT) begin
                m_mode = M_HALT;
            end else begin
                for (int i = 0; i < NE; i++)
                    if (first < 0 && m_match[i] == m_addr && cond_holds(m_cond[i], f))
                        first = i;
                if (first >= 0) begin
                    m_addr  = m_tgt[first];
                    m_taken = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_addr = (m_addr + 1) % 256;
                end
            end
        end
        if (we) begin
            m_match[idx] = int'(d[18:11]);
            m_cond[idx]  = int'(d[10:8]);
            m_tgt[idx]   = int'(d[7:0]);
        end
    endfunction

    function automatic logic [18:0] pack(int m, int c, int t);
        return {8'(m), 3'(c), 8'(t)};
    endfunction

    // One clock: apply inputs, let the edge happen, advance the model, settle.
    task automatic tick(input bit st, input bit sl, input logic [3:0] f,
                        input bit we, input int idx, input logic [18:0] d);
        start    = st;
        stall    = sl;
        ALUFlags = f;
        cfg_we   = we;
        cfg_idx  = 3'(idx);
        cfg_data = d;
        @(posedge clk);
        model_edge(st, sl, f, we, idx, d);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        start = 0; stall = 0; ALUFlags = 0; cfg_we = 0; cfg_idx = 0; cfg_data = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({InstrAddr, running, halted, branch_taken} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr/run/halt/bt = %0d/%b/%b/%b, want 0/0/0/0",
                     InstrAddr, running, halted, branch_taken);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(0, 1'($urandom), 4'($urandom), 0, 0, '0);
            checks++;
            if ({InstrAddr, running, halted, branch_taken} !==
                {8'(m_addr), m_mode == M_RUN, m_mode == M_HALT, m_taken}) begin
                errors++;
                $display("FAIL idle_hold: addr/run/halt/bt = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                         InstrAddr, running, halted, branch_taken,
                         m_addr, m_mode == M_RUN, m_mode == M_HALT, m_taken);
            end
        end
    endtask

    task automatic test_linear();
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int k = 0; k < 43; k++) begin
            checks++;
            if ({InstrAddr, running, halted, branch_taken} !==
                {8'(m_addr), m_mode == M_RUN, m_mode == M_HALT, m_taken}) begin
                errors++;
                $display("FAIL linear cyc%0d: addr/run/halt/bt = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                         k, InstrAddr, running, halted, branch_taken,
                         m_addr, m_mode == M_RUN, m_mode == M_HALT, m_taken);
            end
            // start is random while running (must be ignored), quiet once parked
            tick((m_mode == M_RUN) ? 1'($urandom) : 1'b0, 0, 4'($urandom), 0, 0, '0);
        end
        checks++;
        if (InstrAddr !== 8'd31 || halted !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL linear_park: addr/halt/run = %0d/%b/%b, want 31/1/0",
                     InstrAddr, halted, running);
        end
    endtask

    task automatic test_loop();
        int         seq[14];
        int         z_visits = 0;
        int         pulses = 0;
        logic [3:0] f;
        seq = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 5};
        tick(0, 0, 4'h0, 1, 0, pack(4, 1, 1));
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin
                f = 4'($urandom);
                if (m_addr == 4) begin
                    f[0] = (z_visits < 2);
                    z_visits++;
                end
                tick(1'($urandom), 0, f, 0, 0, '0);
            end
            if (branch_taken === 1'b1) pulses++;
            checks++;
            if ({InstrAddr, running, halted, branch_taken} !==
                {8'(m_addr), m_mode == M_RUN, m_mode == M_HALT, m_taken}) begin
                errors++;
                $display("FAIL loop cyc%0d: addr/run/halt/bt = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                         k, InstrAddr, running, halted, branch_taken,
                         m_addr, m_mode == M_RUN, m_mode == M_HALT, m_taken);
            end
            checks++;
            if (InstrAddr !== 8'(seq[k])) begin
                errors++;
                $display("FAIL loop_seq step%0d: addr %0d, want %0d", k, InstrAddr, seq[k]);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL loop_pulses: branch_taken pulsed %0d times, want 2", pulses);
        end
        for (int n = 0; n < 60 && halted !== 1'b1; n++)
            tick(1'($urandom), 0, 4'($urandom), 0, 0, '0);
        checks++;
        if (halted !== 1'b1 || InstrAddr !== 8'd31) begin
            errors++;
            $display("FAIL loop_halt: halt/addr %b/%0d, want 1/31", halted, InstrAddr);
        end
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        checks++;
        if (taken_count !== 16'd2) begin
            errors++;
            $display("FAIL loop_count: taken_count %0d, want 2", taken_count);
        end
`endif
        tick(1, 0, 4'($urandom), 0, 0, '0);
        checks++;
        if (InstrAddr !== 8'd0 || running !== 1'b1) begin
            errors++;
            $display("FAIL loop_restart: addr/run %0d/%b, want 0/1", InstrAddr, running);
        end
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
        checks++;
        if (taken_count !== 16'd0) begin
            errors++;
            $display("FAIL loop_count_clr: taken_count %0d, want 0", taken_count);
        end
`endif
        tick(0, 0, 4'h0, 1, 0, pack(0, 0, 0));
        for (int n = 0; n < 60 && halted !== 1'b1; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
    endtask

    task automatic test_priority();
        tick(0, 0, 4'h0, 1, 2, pack(8, 2, 8));
        tick(0, 0, 4'h0, 1, 1, pack(8, 7, 20));
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int n = 0; n < 20 && InstrAddr !== 8'd8; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
        checks++;
        if (InstrAddr !== 8'd8) begin
            errors++;
            $display("FAIL prio_reach: addr %0d, want 8", InstrAddr);
        end
        tick(0, 0, 4'($urandom) & 4'b1110, 0, 0, '0);
        checks++;
        if (InstrAddr !== 8'd20 || branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL prio_branch: addr/bt %0d/%b, want 20/1", InstrAddr, branch_taken);
        end
        for (int n = 0; n < 30 && halted !== 1'b1; n++) begin
            tick(1'($urandom), 0, 4'($urandom), 0, 0, '0);
            checks++;
            if ({InstrAddr, running, halted, branch_taken} !==
                {8'(m_addr), m_mode == M_RUN, m_mode == M_HALT, m_taken}) begin
                errors++;
                $display("FAIL prio cyc%0d: addr/run/halt/bt = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                         n, InstrAddr, running, halted, branch_taken,
                         m_addr, m_mode == M_RUN, m_mode == M_HALT, m_taken);
            end
        end
    endtask

    task automatic test_stall();
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int n = 0; n < 20 && InstrAddr !== 8'd6; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
        checks++;
        if (InstrAddr !== 8'd6) begin
            errors++;
            $display("FAIL stall_reach: addr %0d, want 6", InstrAddr);
        end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) tick(1'($urandom), 1, 4'($urandom), 0, 0, '0);
            else       tick(0, 0, 4'($urandom), 0, 0, '0);
            checks++;
            if (InstrAddr !== ((k < 3) ? 8'd6 : 8'd7) || branch_taken !== 1'b0 ||
                InstrAddr !== 8'(m_addr)) begin
                errors++;
                $display("FAIL stall cyc%0d: addr/bt %0d/%b, want %0d/0",
                         k, InstrAddr, branch_taken, (k < 3) ? 6 : 7);
            end
        end
    endtask

    task automatic test_reset_mid();
        int prev;
        bit saw_taken = 1'b0;
        // Entry 3 carries the run 20..25 back to 12 so address 12 is reachable.
        tick(0, 0, 4'($urandom), 1, 3, pack(25, 7, 12));
        for (int n = 0; n < 60 && InstrAddr !== 8'd12; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
        checks++;
        if (InstrAddr !== 8'd12 || running !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach: addr/run %0d/%b, want 12/1", InstrAddr, running);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({InstrAddr, running, halted, branch_taken} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: addr/run/halt/bt = %0d/%b/%b/%b, want 0/0/0/0",
                     InstrAddr, running, halted, branch_taken);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int n = 0; n < 40 && halted !== 1'b1; n++) begin
            prev = int'(InstrAddr);
            tick(1'($urandom), 0, 4'($urandom), 0, 0, '0);
            if (branch_taken !== 1'b0) saw_taken = 1'b1;
            if (prev == 8) begin
                checks++;
                if (InstrAddr !== 8'd9) begin
                    errors++;
                    $display("FAIL rstmid_pass8: after 8 addr %0d, want 9", InstrAddr);
                end
            end
        end
        checks++;
        if (saw_taken || halted !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_cleared: taken seen %b halt %b, want 0/1", saw_taken, halted);
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 4'h0, 1, 4, pack(10, 7, 254));
        tick(1, 0, 4'($urandom), 0, 0, '0);
        for (int n = 0; n < 20 && InstrAddr !== 8'd254; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (InstrAddr !== 8'(254 + k) || InstrAddr !== 8'(m_addr)) begin
                errors++;
                $display("FAIL wrap step%0d: addr %0d, want %0d", k, InstrAddr, (254 + k) % 256);
            end
            tick(0, 0, 4'($urandom), k == 0, 4, pack(0, 0, 0));
        end
        for (int n = 0; n < 40 && halted !== 1'b1; n++)
            tick(0, 0, 4'($urandom), 0, 0, '0);
    endtask

    task automatic test_random();
        bit st;
        int m;
        int t;
        for (int i = 0; i < NE; i++) begin
            m = ($urandom % 5 == 0) ? int'($urandom % 256) : int'($urandom % 40);
            t = ($urandom % 4 == 0) ? 248 + int'($urandom % 8) : int'($urandom % 40);
            tick(0, 0, 4'h0, 1, i, pack(m, $urandom % 8, t));
        end
        for (int k = 0; k < 3000; k++) begin
            st = (m_mode == M_RUN) ? 1'($urandom) : ($urandom % 4 == 0);
            m  = ($urandom % 5 == 0) ? int'($urandom % 256) : int'($urandom % 40);
            t  = ($urandom % 4 == 0) ? 248 + int'($urandom % 8) : int'($urandom % 40);
            tick(st, $urandom % 5 == 0, 4'($urandom), $urandom % 8 == 0,
                 $urandom % NE, pack(m, $urandom % 8, t));
            checks++;
            if ({InstrAddr, running, halted, branch_taken} !==
                {8'(m_addr), m_mode == M_RUN, m_mode == M_HALT, m_taken}) begin
                errors++;
                $display("FAIL random cyc%0d: addr/run/halt/bt = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                         k, InstrAddr, running, halted, branch_taken,
                         m_addr, m_mode == M_RUN, m_mode == M_HALT, m_taken);
            end
`ifdef BRANCH_SEQ_TAKEN_CNT_EN
            checks++;
            if (taken_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_count cyc%0d: taken_count %0d, model %0d",
                         k, taken_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_loop();
        test_priority();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
